hazard_stall_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core and successor to the single-cycle load-use/branch unit. Sits beside the ID stage and drives PC write-enable, IF/ID write-enable, per-stage flushes and an EX hold.
- Generalises load-use stalling to LOAD_LAT cycles.
- Adds multi-cycle multiply hold with a down-counter FSM.
- Excludes register $0 and honours per-operand "used" qualifiers.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_cmp.sv | 20 ++
 rtl/hazard_stall_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state encoding, control-bundle layout and default latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_BUSY   = 2'd2
  } state_e;

  localparam int REG_ZERO = 0;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int LOAD_LAT_DEF   = 1;
  localparam int MUL_LAT_DEF    = 4;
  localparam int CNT_W_DEF      = 4;

  typedef struct packed {
    logic pc_write;
    logic if_write;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
    logic ex_hold;
  } ctrl_t;

  // Field order: pc_write, if_write, if_flush, id_flush, ex_flush, ex_hold
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_MUL    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_LOAD   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_cmp.sv
// Operand-match comparator: flags a load-use dependency for one source operand.
// Register $0 never creates a dependency, and unused operands are masked.
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic                  src_used_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
  input  logic                  ex_memread_i,
  output logic                  match_o
);

  assign match_o = ex_memread_i
                 & (ex_rt_addr_i != REG_ADDR_W'(REG_ZERO))
                 & src_used_i
                 & (src_addr_i == ex_rt_addr_i);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller beside ID: load-use stalls, multiply hold, branch flush.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LOAD_LAT   = LOAD_LAT_DEF,
  parameter int MUL_LAT    = MUL_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  branch_taken_i,
  input  logic [REG_ADDR_W-1:0] if_id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] if_id_rt_addr_i,
  input  logic                  if_id_rs_used_i,
  input  logic                  if_id_rt_used_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rt_addr_i,
  input  logic                  id_ex_memread_i,
  input  logic                  id_ex_mul_i,
  output logic                  pc_write_o,
  output logic                  if_write_o,
  output logic                  if_flush_o,
  output logic                  id_flush_o,
  output logic                  ex_flush_o,
  output logic                  ex_hold_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           flush_events_o,
`endif
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MUL_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_LD_INIT  = CNT_W'(LOAD_LAT - 2);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rs_match, rt_match, hazard;
  ctrl_t             ctrl;

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
    .src_addr_i   (if_id_rs_addr_i),
    .src_used_i   (if_id_rs_used_i),
    .ex_rt_addr_i (id_ex_rt_addr_i),
    .ex_memread_i (id_ex_memread_i),
    .match_o      (rs_match)
  );

  hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
    .src_addr_i   (if_id_rt_addr_i),
    .src_used_i   (if_id_rt_used_i),
    .ex_rt_addr_i (id_ex_rt_addr_i),
    .ex_memread_i (id_ex_memread_i),
    .match_o      (rt_match)
  );

  assign hazard = rs_match | rt_match;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (branch_taken_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (id_ex_mul_i) begin
            state_d = MUL_BUSY;
            cnt_d   = CNT_MUL_INIT;
          end else if (hazard && (LOAD_LAT > 1)) begin
            state_d = LOAD_STALL;
            cnt_d   = CNT_LD_INIT;
          end
        end
        LOAD_STALL, MUL_BUSY: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reset overrides everything so the pipeline is held flushed while rst_i is low.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_i) begin
      ctrl = CTRL_RESET;
    end else if (branch_taken_i) begin
      ctrl = CTRL_BRANCH;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (id_ex_mul_i)  ctrl = CTRL_MUL;
          else if (hazard)  ctrl = CTRL_LOAD;
          else              ctrl = CTRL_RUN;
        end
        LOAD_STALL: ctrl = CTRL_LOAD;
        MUL_BUSY:   ctrl = CTRL_MUL;
        default:    ctrl = CTRL_RESET;
      endcase
    end
  end

  assign pc_write_o = ctrl.pc_write;
  assign if_write_o = ctrl.if_write;
  assign if_flush_o = ctrl.if_flush;
  assign id_flush_o = ctrl.id_flush;
  assign ex_flush_o = ctrl.ex_flush;
  assign ex_hold_o  = ctrl.ex_hold;
  assign busy_o     = rst_i & (state_q != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (!ctrl.pc_write && !branch_taken_i && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (branch_taken_i && (flush_events_q != '1))
        flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_events_o = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one instance with LOAD_LAT=1, one with LOAD_LAT=3.
// Output vectors are packed as {pc_write, if_write, if_flush, id_flush, ex_flush, ex_hold, busy}.
module tb_hazard_stall_ctrl;

  localparam logic [6:0] RUN   = 7'b1100000;
  localparam logic [6:0] LOAD  = 7'b0001000;
  localparam logic [6:0] LOADB = 7'b0001001;
  localparam logic [6:0] MUL   = 7'b0000010;
  localparam logic [6:0] MULB  = 7'b0000011;
  localparam logic [6:0] BR    = 7'b1011100;
  localparam logic [6:0] BRB   = 7'b1011101;
  localparam logic [6:0] RST   = 7'b0011100;

  logic       clk = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       br = 1'b0;
  logic [4:0] rs = '0, rt = '0, exrt = '0;
  logic       rsu = 1'b0, rtu = 1'b0, mr = 1'b0, mul = 1'b0;

  logic pc1, ifw1, iff1, idf1, exf1, hold1, busy1;
  logic pc3, ifw3, iff3, idf3, exf3, hold3, busy3;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall1, flush1, stall3, flush3;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wire [6:0] o1 = {pc1, ifw1, iff1, idf1, exf1, hold1, busy1};
  wire [6:0] o3 = {pc3, ifw3, iff3, idf3, exf3, hold3, busy3};

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .MUL_LAT(4), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst_n_in), .branch_taken_i(br),
    .if_id_rs_addr_i(rs), .if_id_rt_addr_i(rt),
    .if_id_rs_used_i(rsu), .if_id_rt_used_i(rtu),
    .id_ex_rt_addr_i(exrt), .id_ex_memread_i(mr), .id_ex_mul_i(mul),
    .pc_write_o(pc1), .if_write_o(ifw1), .if_flush_o(iff1), .id_flush_o(idf1),
    .ex_flush_o(exf1), .ex_hold_o(hold1),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles_o(stall1), .flush_events_o(flush1),
`endif
    .busy_o(busy1)
  );

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .MUL_LAT(4), .CNT_W(4)) dut3 (
    .clk_i(clk), .rst_i(rst_n_in), .branch_taken_i(br),
    .if_id_rs_addr_i(rs), .if_id_rt_addr_i(rt),
    .if_id_rs_used_i(rsu), .if_id_rt_used_i(rtu),
    .id_ex_rt_addr_i(exrt), .id_ex_memread_i(mr), .id_ex_mul_i(mul),
    .pc_write_o(pc3), .if_write_o(ifw3), .if_flush_o(iff3), .id_flush_o(idf3),
    .ex_flush_o(exf3), .ex_hold_o(hold3),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles_o(stall3), .flush_events_o(flush3),
`endif
    .busy_o(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are checked 1ns later.
  task automatic cycle(input logic b, input logic [4:0] a_rs, input logic a_rsu,
                       input logic [4:0] a_rt, input logic a_rtu,
                       input logic [4:0] a_exrt, input logic a_mr, input logic a_mul);
    @(negedge clk);
    br = b; rs = a_rs; rsu = a_rsu; rt = a_rt; rtu = a_rtu;
    exrt = a_exrt; mr = a_mr; mul = a_mul;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #3;
    check("reset_o1", {25'd0, o1}, {25'd0, RST});
    check("reset_o3", {25'd0, o3}, {25'd0, RST});
    @(negedge clk);
    rst_n_in = 1'b1;
    #1;
    check("post_reset_o1", {25'd0, o1}, {25'd0, RUN});
    check("post_reset_o3", {25'd0, o3}, {25'd0, RUN});

    // Load-use on rs=8
    cycle(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    check("lu_rs_c1_o1", {25'd0, o1}, {25'd0, LOAD});
    check("lu_rs_c1_o3", {25'd0, o3}, {25'd0, LOAD});
    idle();
    check("lu_rs_c2_o1", {25'd0, o1}, {25'd0, RUN});
    check("lu_rs_c2_o3", {25'd0, o3}, {25'd0, LOADB});
    idle();
    check("lu_rs_c3_o3", {25'd0, o3}, {25'd0, LOADB});
    idle();
    check("lu_rs_c4_o3", {25'd0, o3}, {25'd0, RUN});

    // $0 destination and unused operand never stall
    cycle(1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("zero_reg_o1", {25'd0, o1}, {25'd0, RUN});
    check("zero_reg_o3", {25'd0, o3}, {25'd0, RUN});
    cycle(1'b0, 5'd3, 1'b1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0);
    check("rt_unused_o1", {25'd0, o1}, {25'd0, RUN});
    check("rt_unused_o3", {25'd0, o3}, {25'd0, RUN});
    cycle(1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    check("no_memread_o1", {25'd0, o1}, {25'd0, RUN});

    // Load-use on rt=5; hazard inputs kept during LOAD_STALL are ignored by dut3
    cycle(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    check("lu_rt_c1_o3", {25'd0, o3}, {25'd0, LOAD});
    check("lu_rt_c1_o1", {25'd0, o1}, {25'd0, LOAD});
    cycle(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    check("lu_rt_c2_o3", {25'd0, o3}, {25'd0, LOADB});
    check("lu_rt_c2_o1", {25'd0, o1}, {25'd0, LOAD});
    idle();
    check("lu_rt_c3_o3", {25'd0, o3}, {25'd0, LOADB});
    check("lu_rt_c3_o1", {25'd0, o1}, {25'd0, RUN});
    idle();
    check("lu_rt_c4_o3", {25'd0, o3}, {25'd0, RUN});

    // Multiply: IDLE cycle plus three MUL_BUSY cycles (counter 2,1,0)
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("mul_c1_o1", {25'd0, o1}, {25'd0, MUL});
    for (int i = 0; i < 3; i++) begin
      idle();
      check($sformatf("mul_busy%0d_o1", i), {25'd0, o1}, {25'd0, MULB});
    end
    idle();
    check("mul_done_o1", {25'd0, o1}, {25'd0, RUN});
    check("mul_done_o3", {25'd0, o3}, {25'd0, RUN});

    // Branch aborts the multiply in the second MUL_BUSY cycle
    cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    check("ab_c1_o1", {25'd0, o1}, {25'd0, MUL});
    idle();
    check("ab_c2_o1", {25'd0, o1}, {25'd0, MULB});
    cycle(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    check("ab_branch_o1", {25'd0, o1}, {25'd0, BRB});
    idle();
    check("ab_after_o1", {25'd0, o1}, {25'd0, RUN});

    // Multiply and load hazard together: multiply wins, load re-evaluated afterwards
    cycle(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    check("both_c1_o1", {25'd0, o1}, {25'd0, MUL});
    check("both_c1_o3", {25'd0, o3}, {25'd0, MUL});
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      check($sformatf("both_busy%0d_o3", i), {25'd0, o3}, {25'd0, MULB});
    end
    cycle(1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    check("both_load_o1", {25'd0, o1}, {25'd0, LOAD});
    check("both_load_o3", {25'd0, o3}, {25'd0, LOAD});
    idle();
    check("both_after_o1", {25'd0, o1}, {25'd0, RUN});
    check("both_after_o3", {25'd0, o3}, {25'd0, LOADB});
    idle();
    idle();
    check("both_end_o3", {25'd0, o3}, {25'd0, RUN});

    // Branch beats a load hazard in IDLE
    cycle(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    check("br_idle_o1", {25'd0, o1}, {25'd0, BR});
    check("br_idle_o3", {25'd0, o3}, {25'd0, BR});
    idle();
    check("br_after_o3", {25'd0, o3}, {25'd0, RUN});

`ifdef HAZARD_PERF_CNT_EN
    check("flush_events_o1", flush1, 32'd2);
`endif

    // Asynchronous reset in the middle of dut3's LOAD_STALL
    cycle(1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    check("ar_c1_o3", {25'd0, o3}, {25'd0, LOAD});
    idle();
    check("ar_c2_o3", {25'd0, o3}, {25'd0, LOADB});
    #1;
    rst_n_in = 1'b0;
    #1;
    check("ar_forced_o3", {25'd0, o3}, {25'd0, RST});
    check("ar_forced_o1", {25'd0, o1}, {25'd0, RST});
    @(negedge clk);
    rst_n_in = 1'b1;
    #1;
    check("ar_release_o3", {25'd0, o3}, {25'd0, RUN});
    check("ar_release_o1", {25'd0, o1}, {25'd0, RUN});
`ifdef HAZARD_PERF_CNT_EN
    check("ar_stall_cnt_o3", stall3, 32'd0);
    check("ar_flush_cnt_o3", flush3, 32'd0);
    check("ar_stall_cnt_o1", stall1, 32'd0);
    check("ar_flush_cnt_o1", flush1, 32'd0);
`endif
    idle();
    check("ar_next_o3", {25'd0, o3}, {25'd0, RUN});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
